// File: rtl/cci_mpf_wr_beat_normalizer_pkg.sv
// Shared types for the C1 write-beat normalizer.
//   t_beat_num       : beat index within a multi-line write (0..3)
//   t_wr_beat_state  : tracker FSM state
//   ERR_*            : bit positions inside t_wr_beat_err
//   t_wr_beat_err    : 5-bit protocol error vector
package cci_mpf_wr_beat_pkg;

  typedef logic [1:0] t_beat_num;

  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } t_wr_beat_state;

  localparam int ERR_NO_SOP    = 0;
  localparam int ERR_SOP_MID   = 1;
  localparam int ERR_LEN_CHG   = 2;
  localparam int ERR_LEN_RANGE = 3;
  localparam int ERR_ALIGN     = 4;
  localparam int N_ERR         = 5;

  typedef logic [N_ERR-1:0] t_wr_beat_err;

endpackage

// File: rtl/cci_mpf_wr_beat_normalizer_if.sv
// C1 write-beat stream bundle around the normalizer.
//   in_*      : AFU-side write beat (valid, sop, cl_len, addr, data)
//   out_*     : FIU-side write beat plus beat index
//   pkt_done  : last beat of a packet at the output
// master: the AFU/FIU environment view. slave: the normalizer view.
interface cci_mpf_wr_beat_normalizer_if #(
  parameter int ADDR_W = 42,
  parameter int DATA_W = 512
);
  logic              in_valid;
  logic              in_sop;
  logic [1:0]        in_cl_len;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_data;

  logic              out_valid;
  logic              out_sop;
  logic [1:0]        out_cl_len;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        out_beat_num;
  logic              pkt_done;

  modport master (
    output in_valid, in_sop, in_cl_len, in_addr, in_data,
    input  out_valid, out_sop, out_cl_len, out_addr, out_data, out_beat_num, pkt_done
  );

  modport slave (
    input  in_valid, in_sop, in_cl_len, in_addr, in_data,
    output out_valid, out_sop, out_cl_len, out_addr, out_data, out_beat_num, pkt_done
  );
endinterface

// File: rtl/cci_mpf_wr_beat_normalizer_pipe.sv
// cci_mpf_wr_beat_pipe: N_STAGES-deep valid + payload register chain.
//   clk, reset : clock, synchronous active-high reset (valids only)
//   vld_in     : valid entering the chain
//   data_in    : W-bit payload entering the chain
//   vld_out    : valid after N_STAGES cycles
//   data_out   : payload after N_STAGES cycles
// N_STAGES == 0 is a straight wire.
module cci_mpf_wr_beat_pipe #(
  parameter int N_STAGES = 1,
  parameter int W        = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         vld_in,
  input  logic [W-1:0] data_in,
  output logic         vld_out,
  output logic [W-1:0] data_out
);

  if (N_STAGES == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ reset;
    assign vld_out  = vld_in;
    assign data_out = data_in;
  end else begin : g_reg
    logic [N_STAGES-1:0] vld_p;
    logic [W-1:0]        data_p [N_STAGES];

    always_ff @(posedge clk) begin
      if (reset) begin
        vld_p <= '0;
      end else begin
        vld_p[0] <= vld_in;
        for (int i = 1; i < N_STAGES; i++) vld_p[i] <= vld_p[i-1];
      end
    end

    // payload registers carry no reset; the valid qualifies them
    always_ff @(posedge clk) begin
      data_p[0] <= data_in;
      for (int i = 1; i < N_STAGES; i++) data_p[i] <= data_p[i-1];
    end

    assign vld_out  = vld_p[N_STAGES-1];
    assign data_out = data_p[N_STAGES-1];
  end

endmodule

// File: rtl/cci_mpf_wr_beat_normalizer.sv
// cci_mpf_wr_beat_normalizer: tracks C1 multi-beat write packets, checks
// SOP/length/alignment, optionally splits packets into 1-line writes, and
// registers the result through N_REG_STAGES output stages.
//   clk, reset  : clock, synchronous active-high reset
//   bus (slave) : in_* write beat in; out_*, out_beat_num, pkt_done out
//   clr_err     : clears err_flags, err_count (and statistics)
//   err_flags   : sticky {align, len range, len change, sop mid, no sop}
//   err_count   : saturating count of beats carrying any error
//   pkt_count   : packets seen at the output (MPF_WR_BEAT_STATS_EN)
//   beat_count  : beats seen at the output (MPF_WR_BEAT_STATS_EN)
// Optional macro MPF_WR_BEAT_STATS_EN enables the statistics counters;
// without it pkt_count/beat_count are constant 0.
module cci_mpf_wr_beat_normalizer
  import cci_mpf_wr_beat_pkg::*;
#(
  parameter int ADDR_W            = 42,
  parameter int DATA_W            = 512,
  parameter int MAX_BEATS         = 4,
  parameter int CONVERT_TO_SINGLE = 0,
  parameter int N_REG_STAGES      = 1
) (
  input  logic         clk,
  input  logic         reset,
  cci_mpf_wr_beat_normalizer_if.slave bus,
  input  logic         clr_err,
  output t_wr_beat_err err_flags,
  output logic [15:0]  err_count,
  output logic [31:0]  pkt_count,
  output logic [31:0]  beat_count
);

  localparam int         PW      = 1 + 2 + ADDR_W + DATA_W + 2 + 1;
  localparam logic [1:0] MAX_LEN = 2'(MAX_BEATS - 1);
  localparam logic [2:0] MAX_B3  = 3'(MAX_BEATS);

  function automatic logic len_bad(input logic [1:0] len);
    return (len == 2'd2) || (({1'b0, len} + 3'd1) > MAX_B3);
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  t_wr_beat_state state, state_nxt;
  t_beat_num      cnt, cnt_nxt;
  logic [1:0]     len_raw_q, len_raw_nxt;   // cl_len as sent at SOP
  logic [1:0]     len_eff_q, len_eff_nxt;   // length actually tracked
  logic [1:0]     addr_lo_q, addr_lo_nxt;

  logic           range_bad;
  logic [1:0]     eff_len;
  t_wr_beat_err   beat_err;
  t_beat_num      beat_num;
  logic           done;
  logic [1:0]     addr_lo_cur;

  assign range_bad = len_bad(bus.in_cl_len);
  assign eff_len   = range_bad ? MAX_LEN : bus.in_cl_len;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    len_raw_q <= len_raw_nxt;
    len_eff_q <= len_eff_nxt;
    addr_lo_q <= addr_lo_nxt;
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    len_raw_nxt = len_raw_q;
    len_eff_nxt = len_eff_q;
    addr_lo_nxt = addr_lo_q;
    beat_err    = '0;
    beat_num    = '0;
    done        = 1'b0;
    addr_lo_cur = addr_lo_q;

    if (bus.in_valid) begin
      if (bus.in_sop) begin
        // any SOP restarts tracking, even in the middle of a packet
        len_raw_nxt = bus.in_cl_len;
        len_eff_nxt = eff_len;
        addr_lo_nxt = bus.in_addr[1:0];
        addr_lo_cur = bus.in_addr[1:0];
        beat_err[ERR_SOP_MID]   = (state == IN_PKT);
        beat_err[ERR_LEN_RANGE] = range_bad;
        beat_err[ERR_ALIGN]     = |(bus.in_addr[1:0] & bus.in_cl_len);
        if (eff_len == 2'd0) begin
          done      = 1'b1;
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          state_nxt = IN_PKT;
          cnt_nxt   = 2'd1;
        end
      end else if (state == IDLE) begin
        // orphan beat: pass it through as a complete single-line write
        beat_err[ERR_NO_SOP] = 1'b1;
        done        = 1'b1;
        addr_lo_cur = bus.in_addr[1:0];
      end else begin
        beat_num = cnt;
        beat_err[ERR_LEN_CHG] = (bus.in_cl_len != len_raw_q);
        if (cnt == len_eff_q) begin
          done      = 1'b1;
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 2'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clr_err) begin
      err_flags <= '0;
      err_count <= '0;
    end else begin
      err_flags <= err_flags | beat_err;
      if (|beat_err) err_count <= sat_inc16(err_count);
    end
  end

  // ---- stage p0: normalized beat, before the output register chain ----
  logic              vld_p0;
  logic              sop_p0;
  logic [1:0]        len_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [PW-1:0]     pay_p0;

  always_comb begin
    if (CONVERT_TO_SINGLE != 0) begin
      sop_p0  = 1'b1;
      len_p0  = 2'd0;
      addr_p0 = {bus.in_addr[ADDR_W-1:2], addr_lo_cur | beat_num};
    end else begin
      sop_p0  = bus.in_sop;
      len_p0  = bus.in_cl_len;
      addr_p0 = bus.in_addr;
    end
  end

  assign vld_p0 = bus.in_valid & ~reset;
  assign pay_p0 = {sop_p0, len_p0, addr_p0, bus.in_data, beat_num, done};

  // ---- output stage: after N_REG_STAGES registers ----
  logic              vld_out;
  logic [PW-1:0]     pay_out;
  logic              sop_out;
  logic [1:0]        len_out;
  logic [ADDR_W-1:0] addr_out;
  logic [DATA_W-1:0] data_out;
  logic [1:0]        bnum_out;
  logic              done_out;

  cci_mpf_wr_beat_pipe #(
    .N_STAGES (N_REG_STAGES),
    .W        (PW)
  ) u_pipe (
    .clk      (clk),
    .reset    (reset),
    .vld_in   (vld_p0),
    .data_in  (pay_p0),
    .vld_out  (vld_out),
    .data_out (pay_out)
  );

  assign {sop_out, len_out, addr_out, data_out, bnum_out, done_out} = pay_out;

  // control fields are qualified by valid so they read 0 between beats
  assign bus.out_valid    = vld_out;
  assign bus.out_sop      = vld_out & sop_out;
  assign bus.out_cl_len   = vld_out ? len_out : 2'd0;
  assign bus.out_addr     = addr_out;
  assign bus.out_data     = data_out;
  assign bus.out_beat_num = vld_out ? bnum_out : 2'd0;
  assign bus.pkt_done     = vld_out & done_out;

`ifdef MPF_WR_BEAT_STATS_EN
  logic [31:0] pkt_cnt_q;
  logic [31:0] beat_cnt_q;

  always_ff @(posedge clk) begin
    if (reset || clr_err) begin
      pkt_cnt_q  <= '0;
      beat_cnt_q <= '0;
    end else begin
      if (vld_out)             beat_cnt_q <= beat_cnt_q + 32'd1;
      if (vld_out && done_out) pkt_cnt_q  <= pkt_cnt_q + 32'd1;
    end
  end

  assign pkt_count  = pkt_cnt_q;
  assign beat_count = beat_cnt_q;
`else
  assign pkt_count  = '0;
  assign beat_count = '0;
`endif

endmodule

// File: tb/tb_cci_mpf_wr_beat_normalizer.sv
// Directed bench for cci_mpf_wr_beat_normalizer. Three instances share one
// stimulus stream: dut0 default (MAX_BEATS=4, pass-through fields), dut1
// with CONVERT_TO_SINGLE=1, dut2 with MAX_BEATS=2. All use one output stage.
// Statistics expectations follow MPF_WR_BEAT_STATS_EN.
module tb_cci_mpf_wr_beat_normalizer;
  import cci_mpf_wr_beat_pkg::*;

  localparam int AW = 42;
  localparam int DW = 64;
`ifdef MPF_WR_BEAT_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk, reset, clr_err;
  logic in_valid, in_sop;
  logic [1:0] in_cl_len;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_data;

  int checks = 0;
  int failures = 0;

  cci_mpf_wr_beat_normalizer_if #(.ADDR_W(AW), .DATA_W(DW)) if0 ();
  cci_mpf_wr_beat_normalizer_if #(.ADDR_W(AW), .DATA_W(DW)) if1 ();
  cci_mpf_wr_beat_normalizer_if #(.ADDR_W(AW), .DATA_W(DW)) if2 ();

  assign if0.in_valid = in_valid;  assign if1.in_valid = in_valid;  assign if2.in_valid = in_valid;
  assign if0.in_sop = in_sop;      assign if1.in_sop = in_sop;      assign if2.in_sop = in_sop;
  assign if0.in_cl_len = in_cl_len; assign if1.in_cl_len = in_cl_len; assign if2.in_cl_len = in_cl_len;
  assign if0.in_addr = in_addr;    assign if1.in_addr = in_addr;    assign if2.in_addr = in_addr;
  assign if0.in_data = in_data;    assign if1.in_data = in_data;    assign if2.in_data = in_data;

  t_wr_beat_err ef0, ef1, ef2;
  logic [15:0]  ec0, ec1, ec2;
  logic [31:0]  pc0, pc1, pc2, bc0, bc1, bc2;

  cci_mpf_wr_beat_normalizer #(.ADDR_W(AW), .DATA_W(DW), .MAX_BEATS(4),
    .CONVERT_TO_SINGLE(0), .N_REG_STAGES(1)) dut0 (
    .clk(clk), .reset(reset), .bus(if0), .clr_err(clr_err),
    .err_flags(ef0), .err_count(ec0), .pkt_count(pc0), .beat_count(bc0));

  cci_mpf_wr_beat_normalizer #(.ADDR_W(AW), .DATA_W(DW), .MAX_BEATS(4),
    .CONVERT_TO_SINGLE(1), .N_REG_STAGES(1)) dut1 (
    .clk(clk), .reset(reset), .bus(if1), .clr_err(clr_err),
    .err_flags(ef1), .err_count(ec1), .pkt_count(pc1), .beat_count(bc1));

  cci_mpf_wr_beat_normalizer #(.ADDR_W(AW), .DATA_W(DW), .MAX_BEATS(2),
    .CONVERT_TO_SINGLE(0), .N_REG_STAGES(1)) dut2 (
    .clk(clk), .reset(reset), .bus(if2), .clr_err(clr_err),
    .err_flags(ef2), .err_count(ec2), .pkt_count(pc2), .beat_count(bc2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic s, input logic [1:0] l,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    in_valid = v; in_sop = s; in_cl_len = l; in_addr = a; in_data = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; in_sop = 1'b0;
    tick();
  endtask

  task automatic clear_errs();
    idle();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; clr_err = 1'b0;
    drive(1'b0, 1'b0, 2'd0, '0, '0);
    repeat (3) tick();
    checks++; if (if0.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", if0.out_valid); end
    checks++; if (if0.pkt_done !== 1'b0) begin failures++; $display("FAIL reset_pkt_done got=%b want=0", if0.pkt_done); end
    checks++; if (ef0 !== 5'b0) begin failures++; $display("FAIL reset_err_flags got=%b want=0", ef0); end
    checks++; if (ec0 !== 16'd0) begin failures++; $display("FAIL reset_err_count got=%0d want=0", ec0); end
    checks++; if (pc0 !== 32'd0 || bc0 !== 32'd0) begin failures++; $display("FAIL reset_stats got=%0d/%0d want=0/0", pc0, bc0); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_legal_4beat();
    for (int b = 0; b < 4; b++) begin
      drive(1'b1, b == 0, 2'd3, 42'h100, 64'hA0 + 64'(b));
      tick();
      checks++; if (if0.out_valid !== 1'b1) begin failures++; $display("FAIL legal_valid b=%0d got=%b want=1", b, if0.out_valid); end
      checks++; if (if0.out_beat_num !== 2'(b)) begin failures++; $display("FAIL legal_beat_num got=%0d want=%0d", if0.out_beat_num, b); end
      checks++; if (if0.pkt_done !== (b == 3)) begin failures++; $display("FAIL legal_pkt_done b=%0d got=%b want=%b", b, if0.pkt_done, b == 3); end
      checks++; if (if0.out_sop !== (b == 0) || if0.out_cl_len !== 2'd3 || if0.out_addr !== 42'h100) begin
        failures++; $display("FAIL legal_fields b=%0d got sop=%b len=%0d addr=%h want sop=%b len=3 addr=100", b, if0.out_sop, if0.out_cl_len, if0.out_addr, b == 0); end
      checks++; if (if1.out_sop !== 1'b1 || if1.out_cl_len !== 2'd0) begin failures++; $display("FAIL conv_sop_len b=%0d got sop=%b len=%0d want sop=1 len=0", b, if1.out_sop, if1.out_cl_len); end
      checks++; if (if1.out_addr !== 42'h100 + 42'(b)) begin failures++; $display("FAIL conv_addr got=%h want=%h", if1.out_addr, 42'h100 + 42'(b)); end
      checks++; if (if1.out_data !== 64'hA0 + 64'(b)) begin failures++; $display("FAIL conv_data got=%h want=%h", if1.out_data, 64'hA0 + 64'(b)); end
    end
    idle();
    checks++; if (if0.out_valid !== 1'b0) begin failures++; $display("FAIL legal_drain got=%b want=0", if0.out_valid); end
    checks++; if (ef0 !== 5'b0 || ef1 !== 5'b0) begin failures++; $display("FAIL legal_no_err got=%b/%b want=0/0", ef0, ef1); end
  endtask

  task automatic test_no_sop();
    clear_errs();
    drive(1'b1, 1'b0, 2'd0, 42'h200, 64'h55);
    tick();
    checks++; if (if0.out_valid !== 1'b1 || if0.pkt_done !== 1'b1 || if0.out_beat_num !== 2'd0) begin
      failures++; $display("FAIL orphan_out got v=%b done=%b bn=%0d want 1/1/0", if0.out_valid, if0.pkt_done, if0.out_beat_num); end
    checks++; if (ef0 !== 5'b00001) begin failures++; $display("FAIL orphan_flags got=%b want=00001", ef0); end
    checks++; if (ec0 !== 16'd1) begin failures++; $display("FAIL orphan_count got=%0d want=1", ec0); end
    // another orphan in the same cycle as clr_err: the clear wins
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    in_valid = 1'b0;
    checks++; if (ef0 !== 5'b0 || ec0 !== 16'd0) begin failures++; $display("FAIL clr_wins got flags=%b count=%0d want 0/0", ef0, ec0); end
  endtask

  task automatic test_sop_mid();
    clear_errs();
    drive(1'b1, 1'b1, 2'd3, 42'h300, 64'h1); tick();
    drive(1'b1, 1'b0, 2'd3, 42'h300, 64'h2); tick();
    drive(1'b1, 1'b1, 2'd1, 42'h310, 64'h3); tick();
    checks++; if (if0.out_beat_num !== 2'd0 || if0.pkt_done !== 1'b0 || if0.out_sop !== 1'b1) begin
      failures++; $display("FAIL sopmid_restart got bn=%0d done=%b sop=%b want 0/0/1", if0.out_beat_num, if0.pkt_done, if0.out_sop); end
    checks++; if (ef0 !== 5'b00010) begin failures++; $display("FAIL sopmid_flags got=%b want=00010", ef0); end
    drive(1'b1, 1'b0, 2'd1, 42'h310, 64'h4); tick();
    checks++; if (if0.out_beat_num !== 2'd1 || if0.pkt_done !== 1'b1) begin
      failures++; $display("FAIL sopmid_second_done got bn=%0d done=%b want 1/1", if0.out_beat_num, if0.pkt_done); end
    checks++; if (ec0 !== 16'd1) begin failures++; $display("FAIL sopmid_count got=%0d want=1", ec0); end
  endtask

  task automatic test_len_change();
    clear_errs();
    drive(1'b1, 1'b1, 2'd1, 42'h400, 64'h5); tick();
    drive(1'b1, 1'b0, 2'd3, 42'h400, 64'h6); tick();
    checks++; if (if0.pkt_done !== 1'b1 || if0.out_beat_num !== 2'd1) begin
      failures++; $display("FAIL lenchg_done got done=%b bn=%0d want 1/1", if0.pkt_done, if0.out_beat_num); end
    checks++; if (ef0 !== 5'b00100) begin failures++; $display("FAIL lenchg_flags got=%b want=00100", ef0); end
  endtask

  task automatic test_range_align();
    clear_errs();
    drive(1'b1, 1'b1, 2'd3, 42'h500, 64'h7); tick();
    checks++; if (if2.pkt_done !== 1'b0) begin failures++; $display("FAIL range_first got=%b want=0", if2.pkt_done); end
    checks++; if (ef2 !== 5'b01000) begin failures++; $display("FAIL range_flags got=%b want=01000", ef2); end
    drive(1'b1, 1'b0, 2'd3, 42'h500, 64'h8); tick();
    checks++; if (if2.pkt_done !== 1'b1 || if2.out_beat_num !== 2'd1) begin
      failures++; $display("FAIL range_done got done=%b bn=%0d want 1/1", if2.pkt_done, if2.out_beat_num); end
    checks++; if (ec2 !== 16'd1) begin failures++; $display("FAIL range_count got=%0d want=1", ec2); end
    clear_errs();
    drive(1'b1, 1'b1, 2'd3, 42'h102, 64'h9); tick();
    checks++; if (ef2 !== 5'b11000) begin failures++; $display("FAIL align_flags_max2 got=%b want=11000", ef2); end
    // dut0 is still two beats into the 0x500 packet, so this SOP is also mid-packet
    checks++; if (ef0 !== 5'b10010) begin failures++; $display("FAIL align_flags_max4 got=%b want=10010", ef0); end
  endtask

  task automatic test_reset_mid();
    idle();
    reset = 1'b1; tick(); reset = 1'b0;
    drive(1'b1, 1'b1, 2'd3, 42'h700, 64'hA); tick();
    reset = 1'b1;
    drive(1'b1, 1'b0, 2'd3, 42'h700, 64'hB); tick();
    reset = 1'b0;
    in_valid = 1'b0;
    checks++; if (if0.out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_flush got=%b want=0", if0.out_valid); end
    drive(1'b1, 1'b1, 2'd0, 42'h800, 64'hC); tick();
    checks++; if (if0.out_valid !== 1'b1 || if0.pkt_done !== 1'b1 || if0.out_beat_num !== 2'd0) begin
      failures++; $display("FAIL rstmid_single got v=%b done=%b bn=%0d want 1/1/0", if0.out_valid, if0.pkt_done, if0.out_beat_num); end
    checks++; if (ef0 !== 5'b0 || ec0 !== 16'd0) begin failures++; $display("FAIL rstmid_no_err got flags=%b count=%0d want 0/0", ef0, ec0); end
  endtask

  task automatic test_len2();
    clear_errs();
    drive(1'b1, 1'b1, 2'd2, 42'h900, 64'hD); tick();
    checks++; if (ef0 !== 5'b01000) begin failures++; $display("FAIL len2_flags got=%b want=01000", ef0); end
    for (int b = 1; b < 4; b++) begin
      drive(1'b1, 1'b0, 2'd2, 42'h900, 64'hD); tick();
    end
    checks++; if (if0.pkt_done !== 1'b1 || if0.out_beat_num !== 2'd3) begin
      failures++; $display("FAIL len2_done got done=%b bn=%0d want 1/3", if0.pkt_done, if0.out_beat_num); end
    checks++; if (ef0 !== 5'b01000 || ec0 !== 16'd1) begin failures++; $display("FAIL len2_sticky got flags=%b count=%0d want 01000/1", ef0, ec0); end
  endtask

  task automatic test_saturate();
    clear_errs();
    drive(1'b1, 1'b0, 2'd0, 42'hA00, 64'hE);
    for (int i = 0; i < 70000; i++) tick();
    idle();
    checks++; if (ec0 !== 16'hFFFF) begin failures++; $display("FAIL sat_count got=%h want=ffff", ec0); end
    checks++; if (ef0 !== 5'b00001) begin failures++; $display("FAIL sat_flags got=%b want=00001", ef0); end
    checks++; if (pc0 !== (STATS ? 32'd70000 : 32'd0)) begin failures++; $display("FAIL stats_pkt got=%0d want=%0d", pc0, STATS ? 70000 : 0); end
    checks++; if (bc0 !== (STATS ? 32'd70000 : 32'd0)) begin failures++; $display("FAIL stats_beat got=%0d want=%0d", bc0, STATS ? 70000 : 0); end
  endtask

  initial begin
    test_reset();
    test_legal_4beat();
    test_no_sop();
    test_sop_mid();
    test_len_change();
    test_range_align();
    test_reset_mid();
    test_len2();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
